vta_mem_read_arbiter: RTL and testbench



---
 rtl/vta_mem_read_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vta_mem_read_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vta_mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) between VTA read clients.
// One burst outstanding at a time; adds BASE_ADDR to client addresses and steers R
// beats to the owning client. Sticky flags report RRESP and RID errors.
module vta_mem_read_arbiter #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ID_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(64'h0000_0020_0000_0000)
) (
    input  logic                             clk,
    input  logic                             rst,
    // Client side
    input  logic [NUM_CLIENTS-1:0]           c_ar_valid,
    output logic [NUM_CLIENTS-1:0]           c_ar_ready,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_ar_addr,
    input  logic [NUM_CLIENTS*8-1:0]         c_ar_len,
    output logic [NUM_CLIENTS-1:0]           c_r_valid,
    input  logic [NUM_CLIENTS-1:0]           c_r_ready,
    output logic [DATA_WIDTH-1:0]            c_r_data,
    output logic                             c_r_last,
    // AXI4 AR master
    output logic                             m_ar_valid,
    input  logic                             m_ar_ready,
    output logic [ADDR_WIDTH-1:0]            m_ar_addr,
    output logic [ID_WIDTH-1:0]              m_ar_id,
    output logic [7:0]                       m_ar_len,
    output logic [2:0]                       m_ar_size,
    output logic [1:0]                       m_ar_burst,
    // AXI4 R master
    input  logic                             m_r_valid,
    output logic                             m_r_ready,
    input  logic [DATA_WIDTH-1:0]            m_r_data,
    input  logic                             m_r_last,
    input  logic [ID_WIDTH-1:0]              m_r_id,
    input  logic [1:0]                       m_r_resp,
    // Error reporting
    output logic                             err_resp,
    output logic                             err_id,
    input  logic                             err_clear
);

    localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [2:0] ArSize = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                  r_state, w_state_next;
    logic [IdxW-1:0]         r_last_grant;
    logic [IdxW-1:0]         r_grant;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic                    r_err_resp;
    logic                    r_err_id;

    logic                    w_win_found;
    logic [IdxW-1:0]         w_win_idx;
    logic [ADDR_WIDTH-1:0]   w_win_addr;
    logic [7:0]              w_win_len;
    logic                    w_ar_hs;
    logic                    w_beat;

    // Round-robin search starting one past the last completed grant, with wrap.
    always_comb begin
        int unsigned w_idx;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_addr  = '0;
        w_win_len   = '0;
        w_idx       = 0;
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            w_idx = (32'(r_last_grant) + k) % NUM_CLIENTS;
            if (!w_win_found && c_ar_valid[w_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = IdxW'(w_idx);
                w_win_addr  = c_ar_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_len   = c_ar_len[w_idx*8 +: 8];
            end
        end
    end

    // rst gating keeps ready low while reset is held even though state is already idle.
    assign w_ar_hs = (r_state == StIdle) && w_win_found && !rst;
    assign w_beat  = (r_state == StData) && m_r_valid && m_r_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_ar_hs) w_state_next = StAddr;
            StAddr:  if (m_ar_ready) w_state_next = StData;
            StData:  if (w_beat && m_r_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic: request accept, AR valid and R steering.
    always_comb begin
        c_ar_ready = '0;
        c_r_valid  = '0;
        m_ar_valid = 1'b0;
        m_r_ready  = 1'b0;
        if (w_ar_hs) begin
            c_ar_ready = NUM_CLIENTS'(1) << w_win_idx;
        end
        if (r_state == StAddr) begin
            m_ar_valid = 1'b1;
        end
        if (r_state == StData) begin
            m_r_ready = c_r_ready[r_grant];
            if (m_r_valid) begin
                c_r_valid = NUM_CLIENTS'(1) << r_grant;
            end
        end
    end

    // Latch the granted request and remember the owner of the last completed burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= IdxW'(NUM_CLIENTS - 1);
            r_grant      <= '0;
            r_addr       <= '0;
            r_len        <= '0;
        end else begin
            if (w_ar_hs) begin
                r_grant <= w_win_idx;
                r_addr  <= w_win_addr + BASE_ADDR;
                r_len   <= w_win_len;
            end
            if (w_beat && m_r_last) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_resp <= 1'b0;
            r_err_id   <= 1'b0;
        end else begin
            r_err_resp <= (r_err_resp && !err_clear) || (w_beat && (m_r_resp != 2'b00));
            r_err_id   <= (r_err_id && !err_clear) ||
                          (w_beat && (m_r_id != ID_WIDTH'(r_grant)));
        end
    end

    assign m_ar_addr  = r_addr;
    assign m_ar_id    = ID_WIDTH'(r_grant);
    assign m_ar_len   = r_len;
    assign m_ar_size  = ArSize;
    assign m_ar_burst = 2'b01;
    assign c_r_data   = m_r_data;
    assign c_r_last   = m_r_last;
    assign err_resp   = r_err_resp;
    assign err_id     = r_err_id;

endmodule

// File: tb/tb_vta_mem_read_arbiter.sv
// Directed bench for vta_mem_read_arbiter with default parameters (4 clients, 64-bit).
module tb_vta_mem_read_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   c_ar_valid;
    logic [3:0]   c_ar_ready;
    logic [255:0] c_ar_addr;
    logic [31:0]  c_ar_len;
    logic [3:0]   c_r_valid;
    logic [3:0]   c_r_ready;
    logic [63:0]  c_r_data;
    logic         c_r_last;
    logic         m_ar_valid;
    logic         m_ar_ready;
    logic [63:0]  m_ar_addr;
    logic [7:0]   m_ar_id;
    logic [7:0]   m_ar_len;
    logic [2:0]   m_ar_size;
    logic [1:0]   m_ar_burst;
    logic         m_r_valid;
    logic         m_r_ready;
    logic [63:0]  m_r_data;
    logic         m_r_last;
    logic [7:0]   m_r_id;
    logic [1:0]   m_r_resp;
    logic         err_resp;
    logic         err_id;
    logic         err_clear;

    int tests_run;
    int tests_failed;

    vta_mem_read_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .c_ar_valid (c_ar_valid),
        .c_ar_ready (c_ar_ready),
        .c_ar_addr  (c_ar_addr),
        .c_ar_len   (c_ar_len),
        .c_r_valid  (c_r_valid),
        .c_r_ready  (c_r_ready),
        .c_r_data   (c_r_data),
        .c_r_last   (c_r_last),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_ar_addr  (m_ar_addr),
        .m_ar_id    (m_ar_id),
        .m_ar_len   (m_ar_len),
        .m_ar_size  (m_ar_size),
        .m_ar_burst (m_ar_burst),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready),
        .m_r_data   (m_r_data),
        .m_r_last   (m_r_last),
        .m_r_id     (m_r_id),
        .m_r_resp   (m_r_resp),
        .err_resp   (err_resp),
        .err_id     (err_id),
        .err_clear  (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [63:0] addr, input logic [7:0] len);
        c_ar_addr[c*64 +: 64] = addr;
        c_ar_len[c*8 +: 8]    = len;
    endtask

    // Accept the pending AR immediately and return len+1 beats to the expected owner.
    task automatic serve(input int id, input int len, input logic [63:0] dbase);
        check("ar_valid", {63'd0, m_ar_valid}, 64'd1);
        check("ar_id", {56'd0, m_ar_id}, 64'(id));
        m_ar_ready = 1'b1;
        tick();
        m_ar_ready = 1'b0;
        c_r_ready  = 4'b1111;
        for (int i = 0; i <= len; i++) begin
            m_r_valid = 1'b1;
            m_r_data  = dbase + 64'(i);
            m_r_last  = (i == len);
            m_r_id    = 8'(id);
            m_r_resp  = 2'b00;
            #1;
            check("r_valid_route", {60'd0, c_r_valid}, 64'(4'b0001 << id));
            check("r_data", c_r_data, dbase + 64'(i));
            check("r_last", {63'd0, c_r_last}, 64'(i == len));
            tick();
        end
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        c_r_ready = 4'b0000;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int beats;
        int cyc;
        logic cr;
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        c_ar_valid = 4'b0100;
        c_ar_addr  = '0;
        c_ar_len   = '0;
        c_r_ready  = 4'b0000;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
        m_r_data   = '0;
        m_r_last   = 1'b0;
        m_r_id     = '0;
        m_r_resp   = '0;
        err_clear  = 1'b0;
        set_req(2, 64'h100, 8'd3);
        #2;
        check("rst_ar_ready", {60'd0, c_ar_ready}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_m_ar_valid", {63'd0, m_ar_valid}, 64'd0);
        check("rst_m_r_ready", {63'd0, m_r_ready}, 64'd0);
        check("rst_c_r_valid", {60'd0, c_r_valid}, 64'd0);
        check("rst_errs", {62'd0, err_resp, err_id}, 64'd0);
        check("rst_ar_addr", m_ar_addr, 64'd0);

        // Single burst from client 2
        check("single_grant", {60'd0, c_ar_ready}, 64'b0100);
        tick();
        c_ar_valid = 4'b0000;
        #1;
        check("single_addr", m_ar_addr, 64'h20_0000_0100);
        check("single_len", {56'd0, m_ar_len}, 64'd3);
        check("single_size", {61'd0, m_ar_size}, 64'd3);
        check("single_burst", {62'd0, m_ar_burst}, 64'd1);
        serve(2, 3, 64'hA0);
        m_r_valid = 1'b1;
        c_r_ready = 4'b1111;
        #1;
        check("idle_c_r_valid", {60'd0, c_r_valid}, 64'd0);
        check("idle_m_r_ready", {63'd0, m_r_ready}, 64'd0);
        m_r_valid = 1'b0;
        c_r_ready = 4'b0000;

        // Round-robin: clients 0,1,3 together after reset
        pulse_reset();
        set_req(0, 64'h0, 8'd0);
        set_req(1, 64'h0, 8'd0);
        set_req(3, 64'h0, 8'd0);
        c_ar_valid = 4'b1011;
        #1;
        check("rr_grant0", {60'd0, c_ar_ready}, 64'b0001);
        tick();
        c_ar_valid = 4'b1010;
        #1;
        check("rr_hold_ready", {60'd0, c_ar_ready}, 64'd0);
        serve(0, 0, 64'h10);
        check("rr_grant1", {60'd0, c_ar_ready}, 64'b0010);
        tick();
        c_ar_valid = 4'b1000;
        #1;
        serve(1, 0, 64'h20);
        check("rr_grant3", {60'd0, c_ar_ready}, 64'b1000);
        tick();
        c_ar_valid = 4'b0000;
        #1;
        serve(3, 0, 64'h30);
        c_ar_valid = 4'b1001;
        #1;
        check("rr_wrap_to0", {60'd0, c_ar_ready}, 64'b0001);
        tick();
        c_ar_valid = 4'b0000;
        #1;
        serve(0, 0, 64'h40);

        // Back-pressure: client 1, len 7, AR stalled 5 cycles, client ready toggling
        set_req(1, 64'h40, 8'd7);
        c_ar_valid = 4'b0010;
        #1;
        check("bp_grant", {60'd0, c_ar_ready}, 64'b0010);
        tick();
        c_ar_valid = 4'b0000;
        set_req(1, 64'hDEAD, 8'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ar_valid", {63'd0, m_ar_valid}, 64'd1);
            check("bp_ar_addr", m_ar_addr, 64'h20_0000_0040);
            check("bp_ar_len", {56'd0, m_ar_len}, 64'd7);
            check("bp_ar_id", {56'd0, m_ar_id}, 64'd1);
            tick();
        end
        m_ar_ready = 1'b1;
        tick();
        m_ar_ready = 1'b0;
        beats = 0;
        cyc   = 0;
        cr    = 1'b0;
        while (beats < 8 && cyc < 40) begin
            c_r_ready = cr ? 4'b0010 : 4'b0000;
            m_r_valid = 1'b1;
            m_r_data  = 64'hB0 + 64'(beats);
            m_r_last  = (beats == 7);
            m_r_id    = 8'd1;
            #1;
            check("bp_r_ready", {63'd0, m_r_ready}, {63'd0, cr});
            check("bp_c_r_valid", {60'd0, c_r_valid}, 64'b0010);
            check("bp_r_data", c_r_data, 64'hB0 + 64'(beats));
            tick();
            if (cr) beats++;
            cr = ~cr;
            cyc++;
        end
        check("bp_beats", 64'(beats), 64'd8);
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        #1;
        check("bp_done_idle", {63'd0, m_r_ready}, 64'd0);
        c_r_ready = 4'b0000;

        // Errors: burst with ARID 0, RRESP error then RID error (with clear pending)
        set_req(0, 64'h0, 8'd1);
        c_ar_valid = 4'b0001;
        #1;
        check("err_grant", {60'd0, c_ar_ready}, 64'b0001);
        tick();
        c_ar_valid = 4'b0000;
        m_ar_ready = 1'b1;
        tick();
        m_ar_ready = 1'b0;
        c_r_ready  = 4'b0001;
        m_r_valid  = 1'b1;
        m_r_data   = 64'hC0;
        m_r_id     = 8'd0;
        m_r_resp   = 2'b10;
        #1;
        check("err_beat0_valid", {60'd0, c_r_valid}, 64'b0001);
        tick();
        check("err_resp_set", {63'd0, err_resp}, 64'd1);
        check("err_id_clean", {63'd0, err_id}, 64'd0);
        m_r_data  = 64'hC1;
        m_r_id    = 8'd5;
        m_r_resp  = 2'b00;
        m_r_last  = 1'b1;
        err_clear = 1'b1;
        #1;
        check("err_beat1_data", c_r_data, 64'hC1);
        tick();
        check("err_resp_cleared", {63'd0, err_resp}, 64'd0);
        check("err_id_beats_clear", {63'd0, err_id}, 64'd1);
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        m_r_id    = 8'd0;
        c_r_ready = 4'b0000;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("err_clear_both", {62'd0, err_resp, err_id}, 64'd0);

        // Address wrap modulo 2^64
        set_req(3, 64'hFFFF_FFE0_0000_0000, 8'd0);
        c_ar_valid = 4'b1000;
        #1;
        check("wrap_grant", {60'd0, c_ar_ready}, 64'b1000);
        tick();
        c_ar_valid = 4'b0000;
        #1;
        check("wrap_addr", m_ar_addr, 64'h0);
        serve(3, 0, 64'hD0);

        // Reset mid-burst after 2 of 4 beats
        set_req(2, 64'h200, 8'd3);
        c_ar_valid = 4'b0100;
        #1;
        check("mid_grant", {60'd0, c_ar_ready}, 64'b0100);
        tick();
        c_ar_valid = 4'b0000;
        m_ar_ready = 1'b1;
        tick();
        m_ar_ready = 1'b0;
        c_r_ready  = 4'b0100;
        m_r_valid  = 1'b1;
        m_r_id     = 8'd2;
        m_r_resp   = 2'b11;
        tick();
        tick();
        c_ar_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        check("mid_c_r_valid", {60'd0, c_r_valid}, 64'd0);
        check("mid_m_r_ready", {63'd0, m_r_ready}, 64'd0);
        check("mid_m_ar_valid", {63'd0, m_ar_valid}, 64'd0);
        check("mid_ar_addr", m_ar_addr, 64'd0);
        check("mid_c_ar_ready", {60'd0, c_ar_ready}, 64'd0);
        check("mid_errs", {62'd0, err_resp, err_id}, 64'd0);
        m_r_valid = 1'b0;
        m_r_resp  = 2'b00;
        c_r_ready = 4'b0000;
        tick();
        rst = 1'b0;
        #1;
        check("mid_first_grant0", {60'd0, c_ar_ready}, 64'b0001);
        c_ar_valid = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
